// File: rtl/load_hazard_scoreboard_pkg.sv
// Shared types and helpers for the core_lapido load-use hazard scoreboard.
package load_hazard_scoreboard_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam logic [RegAddrW-1:0] ZeroReg = '0;

  // One in-flight load: {valid, destination register}.
  typedef struct packed {
    logic                valid;
    logic [RegAddrW-1:0] rd;
  } hazard_slot_t;

  // Number of pending slots behind ID/EX: the ID/EX stage covers the first stall cycle.
  function automatic int unsigned pending_slots(int unsigned load_latency);
    return (load_latency > 0) ? load_latency - 1 : 0;
  endfunction

  // Counter width able to hold n-1, never less than one bit.
  function automatic int unsigned count_width(int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/load_hazard_scoreboard_if.sv
// Pipeline-side bundle between the ID stage and the hazard scoreboard.
interface load_hazard_scoreboard_if
  import load_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = RegAddrW,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned CNT_W      = 16
);

  logic                          ID_EX_is_load;
  logic [REG_ADDR_W-1:0]         ID_EX_rt;
  logic [NUM_SRC*REG_ADDR_W-1:0] IF_ID_src;
  logic [NUM_SRC-1:0]            IF_ID_src_used;
  logic                          branch_taken;
  logic                          stall_pipeline;
  logic                          flush_if_id;
  logic [CNT_W-1:0]              stall_cycles;

  // Pipeline side: drives decode state, consumes stall/flush.
  modport master (
    output ID_EX_is_load, ID_EX_rt, IF_ID_src, IF_ID_src_used, branch_taken,
    input  stall_pipeline, flush_if_id, stall_cycles
  );

  // Scoreboard side.
  modport slave (
    input  ID_EX_is_load, ID_EX_rt, IF_ID_src, IF_ID_src_used, branch_taken,
    output stall_pipeline, flush_if_id, stall_cycles
  );

endinterface

// File: rtl/load_hazard_scoreboard_pending_pipe.sv
// Shift register of loads still in flight past ID/EX, with per-source match outputs.
module load_hazard_scoreboard_pending_pipe #(
  parameter int unsigned RegAddrW = 5,
  parameter int unsigned NumSlots = 1,
  parameter int unsigned NumSrc   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  input  logic [RegAddrW-1:0]        in_reg_i,
  input  logic [NumSrc*RegAddrW-1:0] src_i,
  output logic [NumSrc-1:0]          src_match_o
);

  typedef struct packed {
    logic                valid;
    logic [RegAddrW-1:0] rd;
  } slot_t;

  slot_t [NumSlots-1:0] slot_q, slot_d;

  // Advance every cycle, independent of stall; a bubble enters with valid=0.
  always_comb begin
    slot_d          = slot_q;
    slot_d[0].valid = in_valid_i;
    slot_d[0].rd    = in_reg_i;
    for (int k = 1; k < NumSlots; k++) begin
      slot_d[k] = slot_q[k-1];
    end
  end

  // Slot state; flush does not clear it since older loads remain valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  // Source i matches if any valid slot targets the same register.
  always_comb begin
    src_match_o = '0;
    for (int i = 0; i < NumSrc; i++) begin
      for (int k = 0; k < NumSlots; k++) begin
        if (slot_q[k].valid && (slot_q[k].rd == src_i[i*RegAddrW +: RegAddrW])) begin
          src_match_o[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/load_hazard_scoreboard.sv
// Load-use hazard detector for the core_lapido ID stage: stall, branch flush, stall counter.
module load_hazard_scoreboard
  import load_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W    = RegAddrW,
  parameter int unsigned NUM_SRC       = 2,
  parameter int unsigned LOAD_LATENCY  = 1,
  parameter int unsigned FLUSH_CYCLES  = 1,
  parameter int unsigned ZERO_IS_CONST = 1,
  parameter int unsigned CNT_W         = 16
) (
  input logic                     clk,
  input logic                     rst,
  load_hazard_scoreboard_if.slave bus
);

  localparam int unsigned NumPending = pending_slots(LOAD_LATENCY);
  localparam int unsigned FcntW      = count_width(FLUSH_CYCLES);
  localparam logic [FcntW-1:0]      FcntReload = FcntW'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0]      CntMax     = '1;
  localparam logic [REG_ADDR_W-1:0] ZeroRegW   = REG_ADDR_W'(ZeroReg);

  logic [FcntW-1:0]      fcnt_q, fcnt_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [NUM_SRC-1:0]    pend_match;
  logic [REG_ADDR_W-1:0] src_cur;
  logic                  hit_cur;
  logic                  raw_stall;
  logic                  flush;
  logic                  stall;

  if (NumPending > 0) begin : g_pipe
    load_hazard_scoreboard_pending_pipe #(
      .RegAddrW (REG_ADDR_W),
      .NumSlots (NumPending),
      .NumSrc   (NUM_SRC)
    ) u_pending_pipe (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (bus.ID_EX_is_load & ~flush),
      .in_reg_i    (bus.ID_EX_rt),
      .src_i       (bus.IF_ID_src),
      .src_match_o (pend_match)
    );
  end else begin : g_no_pipe
    assign pend_match = '0;
  end

  // Any used source that depends on the ID/EX load or a pending load raises a stall.
  always_comb begin
    raw_stall = 1'b0;
    src_cur   = '0;
    hit_cur   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_cur = bus.IF_ID_src[i*REG_ADDR_W +: REG_ADDR_W];
      hit_cur = (bus.ID_EX_is_load && (bus.ID_EX_rt == src_cur)) || pend_match[i];
      if ((ZERO_IS_CONST != 0) && (src_cur == ZeroRegW)) begin
        hit_cur = 1'b0;
      end
      if (bus.IF_ID_src_used[i] && hit_cur) begin
        raw_stall = 1'b1;
      end
    end
  end

  // Flush wins over stall; both are held low while in reset.
  always_comb begin
    flush = ~rst & (bus.branch_taken | (fcnt_q != '0));
    stall = ~rst & raw_stall & ~flush;
  end

  // Flush countdown restarts on every taken branch rather than accumulating.
  always_comb begin
    fcnt_d = fcnt_q;
    if (bus.branch_taken) begin
      fcnt_d = FcntReload;
    end else if (fcnt_q != '0) begin
      fcnt_d = fcnt_q - 1'b1;
    end
  end

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Flush counter and stall counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_pipeline = stall;
  assign bus.flush_if_id    = flush;
  assign bus.stall_cycles   = stall_cnt_q;

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// Randomised and directed check of two scoreboard configurations against a cycle-age model.
module tb_load_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  load_hazard_scoreboard_if #(.REG_ADDR_W(5), .NUM_SRC(2), .CNT_W(4))  bus_a ();
  load_hazard_scoreboard_if #(.REG_ADDR_W(5), .NUM_SRC(2), .CNT_W(16)) bus_b ();

  load_hazard_scoreboard #(
    .REG_ADDR_W    (5),
    .NUM_SRC       (2),
    .LOAD_LATENCY  (3),
    .FLUSH_CYCLES  (2),
    .ZERO_IS_CONST (1),
    .CNT_W         (4)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  load_hazard_scoreboard #(
    .REG_ADDR_W    (5),
    .NUM_SRC       (2),
    .LOAD_LATENCY  (1),
    .FLUSH_CYCLES  (1),
    .ZERO_IS_CONST (0),
    .CNT_W         (16)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // Model: a load issued (unflushed) at cycle c is visible while now - c < latency.
  typedef struct {
    int         inst;
    int         cyc;
    logic [4:0] rg;
  } load_rec_t;

  load_rec_t lq[$];
  int        lat[2]    = '{3, 1};
  int        fl_len[2] = '{2, 1};
  bit        zc[2]     = '{1'b1, 1'b0};
  int        cmax[2]   = '{15, 65535};
  int        last_br[2];
  int        cnt_m[2];
  int        cyc;
  int        n_checks;
  int        n_errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic bit model_match(int d, logic [4:0] r, logic ld, logic [4:0] rt);
    if (zc[d] && (r == 5'd0)) return 1'b0;
    if (ld && (rt == r)) return 1'b1;
    foreach (lq[k]) begin
      if ((lq[k].inst == d) && (cyc - lq[k].cyc < lat[d]) && (lq[k].rg == r)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    lq.delete();
    for (int d = 0; d < 2; d++) begin
      last_br[d] = -1000;
      cnt_m[d]   = 0;
    end
  endtask

  // One clock: drive inputs after the edge, check combinational outputs, advance the model.
  task automatic step(input logic ld, input logic [4:0] rt, input logic [4:0] s0,
                      input logic [4:0] s1, input logic [1:0] used, input logic br,
                      input logic r);
    bit         fl_e[2];
    bit         st_e[2];
    logic       got_st;
    logic       got_fl;
    logic [31:0] got_cnt;
    @(posedge clk);
    #2;
    rst                  = r;
    bus_a.ID_EX_is_load  = ld;
    bus_a.ID_EX_rt       = rt;
    bus_a.IF_ID_src      = {s1, s0};
    bus_a.IF_ID_src_used = used;
    bus_a.branch_taken   = br;
    bus_b.ID_EX_is_load  = ld;
    bus_b.ID_EX_rt       = rt;
    bus_b.IF_ID_src      = {s1, s0};
    bus_b.IF_ID_src_used = used;
    bus_b.branch_taken   = br;
    #2;
    for (int d = 0; d < 2; d++) begin
      fl_e[d] = br || (cyc - last_br[d] < fl_len[d]);
      st_e[d] = !r && !fl_e[d] &&
                ((used[0] && model_match(d, s0, ld, rt)) ||
                 (used[1] && model_match(d, s1, ld, rt)));
      got_st  = (d == 0) ? bus_a.stall_pipeline : bus_b.stall_pipeline;
      got_fl  = (d == 0) ? bus_a.flush_if_id : bus_b.flush_if_id;
      got_cnt = (d == 0) ? 32'(bus_a.stall_cycles) : 32'(bus_b.stall_cycles);
      check_eq((d == 0) ? "a_stall" : "b_stall", 32'(got_st), 32'(st_e[d]));
      check_eq((d == 0) ? "a_flush" : "b_flush", 32'(got_fl), 32'(!r && fl_e[d]));
      check_eq((d == 0) ? "a_count" : "b_count", got_cnt, 32'(cnt_m[d]));
    end
    if (r) begin
      model_reset();
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (st_e[d] && (cnt_m[d] < cmax[d])) cnt_m[d]++;
        if (br) last_br[d] = cyc;
        if (ld && !fl_e[d]) lq.push_back('{inst: d, cyc: cyc, rg: rt});
      end
    end
    for (int k = lq.size() - 1; k >= 0; k--) begin
      if (cyc - lq[k].cyc >= 4) lq.delete(k);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    model_reset();
    bus_a.ID_EX_is_load = 1'b0; bus_a.ID_EX_rt = '0; bus_a.IF_ID_src = '0;
    bus_a.IF_ID_src_used = '0; bus_a.branch_taken = 1'b0;
    bus_b.ID_EX_is_load = 1'b0; bus_b.ID_EX_rt = '0; bus_b.IF_ID_src = '0;
    bus_b.IF_ID_src_used = '0; bus_b.branch_taken = 1'b0;

    // Reset state.
    step(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1);
    step(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1);
    idle(2);

    // Load rt=5 with dependent src0=5, then the dependent waits behind a bubble.
    step(1'b1, 5'd5, 5'd5, 5'd1, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 5'd5, 5'd1, 2'b01, 1'b0, 1'b0);
    idle(3);

    // Load rt=7 then dependent src1=7; then same load with src1 unused.
    step(1'b1, 5'd7, 5'd2, 5'd3, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 5'd2, 5'd7, 2'b10, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 5'd7, 5'd2, 5'd7, 2'b01, 1'b0, 1'b0);
    idle(3);

    // Register 0 hazard: suppressed on dut_a, real on dut_b.
    step(1'b1, 5'd0, 5'd0, 5'd4, 2'b01, 1'b0, 1'b0);
    idle(3);

    // Branch alongside a hazard, then a second branch one cycle later.
    step(1'b1, 5'd6, 5'd6, 5'd0, 2'b01, 1'b1, 1'b0);
    step(1'b0, 5'd0, 5'd6, 5'd0, 2'b01, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0);
    idle(4);

    // Reset asserted in the middle of a stall.
    step(1'b1, 5'd9, 5'd9, 5'd0, 2'b01, 1'b0, 1'b0);
    step(1'b0, 5'd0, 5'd9, 5'd0, 2'b01, 1'b0, 1'b0);
    step(1'b0, 5'd0, 5'd9, 5'd0, 2'b01, 1'b0, 1'b1);
    step(1'b0, 5'd0, 5'd9, 5'd0, 2'b01, 1'b0, 1'b0);
    idle(2);

    // Twenty-cycle continuous stall: dut_a saturates at 15.
    step(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 5'd5, 5'd5, 5'd0, 2'b01, 1'b0, 1'b0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    check_eq("a_saturated", 32'(bus_a.stall_cycles), 32'd15);
    check_eq("b_twenty", 32'(bus_b.stall_cycles), 32'd20);
    idle(3);

    // Random traffic on a small register range to make hazards frequent.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 39) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
